// File: rtl/icap_pkg.sv
// Shared ICAP command words, warm-boot FSM state type and the per-byte bit reversal
// that ICAP expects on its 32-bit data port.
package icap_pkg;

    localparam logic [31:0] DUMMY     = 32'hFFFF_FFFF;
    localparam logic [31:0] SYNC      = 32'h5599_AA66;
    localparam logic [31:0] NOOP      = 32'h0400_0000;
    localparam logic [31:0] WR_WBSTAR = 32'h0C40_0080;
    localparam logic [31:0] WR_CMD    = 32'h0C00_0180;
    localparam logic [31:0] IPROG     = 32'h0000_00F0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    // Each byte has its bit order reversed; byte lanes keep their positions.
    function automatic logic [31:0] bitswap(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[b*8 + i] = x[b*8 + 7 - i];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] icap_word(input logic [2:0] idx, input logic [31:0] addr);
        logic [31:0] w;
        case (idx)
            3'd0:    w = DUMMY;
            3'd1:    w = SYNC;
            3'd2:    w = NOOP;
            3'd3:    w = WR_WBSTAR;
            3'd4:    w = bitswap(addr);
            3'd5:    w = WR_CMD;
            3'd6:    w = IPROG;
            default: w = NOOP;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/press_qualifier.sv
// Counts consecutive high cycles of the request and flags the edge on which the
// HOLD_CYCLES-th consecutive high sample arrives.
module press_qualifier #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_enable,
    input  logic i_req,
    output logic o_qualified
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] r_count;

    // r_count holds the number of high samples already seen before this edge.
    assign o_qualified = i_enable & i_req & (r_count == LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count <= '0;
        end else if (i_enable && i_req && !o_qualified) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= '0;
        end
    end

endmodule

// File: rtl/icap_warmboot_seq.sv
// Warm-boot sequencer: qualifies a held boot request, then writes WBSTAR + IPROG through ICAP.
// Define ICAPE2_PRIM_EN to also instantiate the ICAPE2 primitive on the same signals.
module icap_warmboot_seq
    import icap_pkg::*;
#(
    parameter int          HOLD_CYCLES  = 1,
    parameter int          NUM_IMAGES   = 2,
    parameter logic [31:0] IMAGE_STRIDE = 32'h0040_0000,
    localparam int         SELW         = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            boot_req,
    input  logic [SELW-1:0] image_sel,
    output logic            icap_csib,
    output logic            icap_rdwrb,
    output logic [31:0]     icap_din,
    output logic            busy,
    output logic            done
);

    state_t          r_state;
    logic            r_csib;
    logic            r_rdwrb;
    logic [31:0]     r_din;
    logic            r_busy;
    logic            r_done;
    logic [SELW-1:0] r_sel;
    logic [2:0]      r_idx;

    logic            w_enable;
    logic            w_qual;
    logic [31:0]     w_sel_eff;
    logic [31:0]     w_addr;

    assign w_enable  = (r_state == IDLE) || (r_state == HOLD);
    assign w_sel_eff = (int'(r_sel) < NUM_IMAGES) ? 32'(r_sel) : 32'd0;
    assign w_addr    = w_sel_eff * IMAGE_STRIDE;

    press_qualifier #(.HOLD_CYCLES(HOLD_CYCLES)) u_press_qualifier (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_enable    (w_enable),
        .i_req       (boot_req),
        .o_qualified (w_qual)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_csib  <= 1'b1;
            r_rdwrb <= 1'b1;
            r_din   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sel   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    // W0 is registered on the qualifying edge so it appears the very next cycle.
                    if (w_qual) begin
                        r_state <= SEND;
                        r_sel   <= image_sel;
                        r_idx   <= 3'd0;
                        r_din   <= icap_word(3'd0, 32'd0);
                        r_csib  <= 1'b0;
                        r_rdwrb <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (boot_req) begin
                        r_state <= HOLD;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                SEND: begin
                    if (r_idx == 3'd7) begin
                        r_state <= DONE;
                        r_csib  <= 1'b1;
                        r_rdwrb <= 1'b1;
                        r_din   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                        r_din <= icap_word(r_idx + 3'd1, w_addr);
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign icap_csib  = r_csib;
    assign icap_rdwrb = r_rdwrb;
    assign icap_din   = r_din;
    assign busy       = r_busy;
    assign done       = r_done;

`ifdef ICAPE2_PRIM_EN
    ICAPE2 #(
        .ICAP_WIDTH ("X32")
    ) u_icape2 (
        .CLK   (Clk),
        .CSIB  (r_csib),
        .RDWRB (r_rdwrb),
        .I     (r_din),
        .O     ()
    );
`else
`endif

endmodule

// File: tb/tb_icap_warmboot_seq.sv
// Directed bench for icap_warmboot_seq: two parameterisations, expected ICAP words
// queued at stimulus time and popped as the DUT drives them.
module tb_icap_warmboot_seq;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        boot_req_a, boot_req_b;
    logic [1:0]  image_sel_a, image_sel_b;
    logic        icap_csib_a, icap_rdwrb_a, busy_a, done_a;
    logic        icap_csib_b, icap_rdwrb_b, busy_b, done_b;
    logic [31:0] icap_din_a, icap_din_b;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    icap_warmboot_seq #(.HOLD_CYCLES(1), .NUM_IMAGES(4), .IMAGE_STRIDE(32'h0040_0000)) u_a (
        .Clk(Clk), .Reset(Reset), .boot_req(boot_req_a), .image_sel(image_sel_a),
        .icap_csib(icap_csib_a), .icap_rdwrb(icap_rdwrb_a), .icap_din(icap_din_a),
        .busy(busy_a), .done(done_a)
    );

    icap_warmboot_seq #(.HOLD_CYCLES(5), .NUM_IMAGES(3), .IMAGE_STRIDE(32'h0040_0000)) u_b (
        .Clk(Clk), .Reset(Reset), .boot_req(boot_req_b), .image_sel(image_sel_b),
        .icap_csib(icap_csib_b), .icap_rdwrb(icap_rdwrb_b), .icap_din(icap_din_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_swap(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[(i / 8) * 8 + 7 - (i % 8)] = x[i];
        return r;
    endfunction

    // Push the expected word stream; nwords < 8 models an aborted sequence.
    task automatic push_seq(input bit to_b, input int sel, input int nimg, input int nwords);
        logic [31:0] addr;
        logic [31:0] w[8];
        addr = (sel < nimg) ? 32'(sel) * 32'h0040_0000 : 32'd0;
        w[0] = 32'hFFFF_FFFF; w[1] = 32'h5599_AA66; w[2] = 32'h0400_0000; w[3] = 32'h0C40_0080;
        w[4] = model_swap(addr); w[5] = 32'h0C00_0180; w[6] = 32'h0000_00F0; w[7] = 32'h0400_0000;
        for (int i = 0; i < nwords; i++) begin
            if (to_b) qb.push_back(w[i]);
            else      qa.push_back(w[i]);
        end
    endtask

    always @(negedge Clk) begin
        if (icap_csib_a === 1'b0) begin
            check("a_rdwrb_low", {31'd0, icap_rdwrb_a}, 32'd0);
            if (qa.size() == 0) check("a_unexpected_csib", {31'd0, icap_csib_a}, 32'd1);
            else                check("a_word", icap_din_a, qa.pop_front());
        end
        if (icap_csib_b === 1'b0) begin
            check("b_rdwrb_low", {31'd0, icap_rdwrb_b}, 32'd0);
            if (qb.size() == 0) check("b_unexpected_csib", {31'd0, icap_csib_b}, 32'd1);
            else                check("b_word", icap_din_b, qb.pop_front());
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_end_a(input string tag);
        check({tag, "_csib"}, {31'd0, icap_csib_a}, 32'd1);
        check({tag, "_rdwrb"}, {31'd0, icap_rdwrb_a}, 32'd1);
        check({tag, "_din"}, icap_din_a, 32'd0);
        check({tag, "_done"}, {31'd0, done_a}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        check({tag, "_drained"}, qa.size(), 32'd0);
    endtask

    task automatic run_full_a(input int sel, input string tag);
        image_sel_a = 2'(sel);
        push_seq(1'b0, sel, 4, 8);
        boot_req_a = 1'b1;
        tick();
        boot_req_a = 1'b0;
        check({tag, "_w0_timing"}, {31'd0, icap_csib_a}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
        repeat (8) tick();
        check_end_a(tag);
    endtask

    initial begin
        int low_cnt;
        Reset = 1'b1; boot_req_a = 1'b0; boot_req_b = 1'b0;
        image_sel_a = '0; image_sel_b = '0;
        repeat (3) tick();
        check("rst_a_csib", {31'd0, icap_csib_a}, 32'd1);
        check("rst_a_rdwrb", {31'd0, icap_rdwrb_a}, 32'd1);
        check("rst_a_din", icap_din_a, 32'd0);
        check("rst_a_busy", {31'd0, busy_a}, 32'd0);
        check("rst_a_done", {31'd0, done_a}, 32'd0);
        check("rst_b_csib", {31'd0, icap_csib_b}, 32'd1);
        check("rst_b_busy", {31'd0, busy_b}, 32'd0);
        Reset = 1'b0;
        tick();

        // Image 0, single-cycle press.
        run_full_a(0, "a_img0");

        // Request held high in DONE must not restart the sequence.
        low_cnt = 0;
        boot_req_a = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (icap_csib_a === 1'b0) low_cnt++;
        end
        boot_req_a = 1'b0;
        check("a_done_ignores_req", low_cnt, 32'd0);
        check("a_done_sticky", {31'd0, done_a}, 32'd1);

        Reset = 1'b1; tick(); Reset = 1'b0;
        check("a_rst_clears_done", {31'd0, done_a}, 32'd0);
        run_full_a(1, "a_img1");

        // Reset during W3 aborts; then a fresh request runs to completion.
        Reset = 1'b1; tick(); Reset = 1'b0;
        image_sel_a = 2'd2;
        push_seq(1'b0, 2, 4, 4);
        boot_req_a = 1'b1;
        tick();
        boot_req_a = 1'b0;
        repeat (3) tick();
        check("a_abort_w3_present", icap_din_a, 32'h0C40_0080);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("a_abort_csib", {31'd0, icap_csib_a}, 32'd1);
        check("a_abort_busy", {31'd0, busy_a}, 32'd0);
        check("a_abort_done", {31'd0, done_a}, 32'd0);
        check("a_abort_drained", qa.size(), 32'd0);
        repeat (3) tick();
        check("a_abort_no_more", {31'd0, icap_csib_a}, 32'd1);
        run_full_a(3, "a_img3");

        // B: 4-cycle press is too short.
        boot_req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b_short_csib", {31'd0, icap_csib_b}, 32'd1);
            check("b_short_busy", {31'd0, busy_b}, 32'd1);
        end
        boot_req_b = 1'b0;
        tick();
        check("b_short_busy_clear", {31'd0, busy_b}, 32'd0);
        repeat (3) tick();
        check("b_short_csib_idle", {31'd0, icap_csib_b}, 32'd1);

        // B: 5-cycle press, out-of-range select, select toggled during SEND.
        image_sel_b = 2'd3;
        push_seq(1'b1, 3, 3, 8);
        boot_req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b_prequal_csib", {31'd0, icap_csib_b}, 32'd1);
        end
        tick();
        boot_req_b = 1'b0;
        check("b_start_cycle6", {31'd0, icap_csib_b}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            image_sel_b = 2'(i % 3);
            boot_req_b = i[0];
            tick();
        end
        boot_req_b = 1'b0;
        check("b_end_csib", {31'd0, icap_csib_b}, 32'd1);
        check("b_end_done", {31'd0, done_b}, 32'd1);
        check("b_end_drained", qb.size(), 32'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icap_warmboot_seq.md
ICAP_WARMBOOT_SEQ -- requirements
Module: icap_warmboot_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1: consecutive high cycles of boot_req needed to qualify a request, range 1..2^20.
REQ-002 SHALL have parameter NUM_IMAGES, default 2: number of selectable boot images, range 1..16.
REQ-003 SHALL have parameter IMAGE_STRIDE, default 32'h0040_0000: flash byte-address spacing between images.
REQ-004 SHALL have ports Clk input 1, the rising-edge clock; and Reset input 1, synchronous, active-high.
REQ-005 SHALL have port boot_req input 1, the warm-boot request (board reset button).
REQ-006 SHALL have port image_sel input SELW, where SELW=max(1,$clog2(NUM_IMAGES)); it is the target image index.
REQ-007 SHALL have ports icap_csib output 1, icap_rdwrb output 1, and icap_din output 32; these are the ICAP write port, with active-low CS and write.
REQ-008 SHALL have ports busy output 1 (hold or sequence in progress) and done output 1 (IPROG issued, sticky).

Function
REQ-009 SHALL implement FSM states IDLE, HOLD, SEND, and DONE.
REQ-010 IDLE: boot_req=1 -> HOLD with hold counter=1; if HOLD_CYCLES=1, go directly to SEND instead and latch image_sel on that edge.
REQ-011 HOLD: counter increments each cycle boot_req=1; boot_req=0 -> IDLE with counter cleared; when counter reaches HOLD_CYCLES -> SEND, latching image_sel on that edge.
REQ-012 SEND: icap_csib=0 and icap_rdwrb=0 for exactly 8 consecutive cycles, with icap_din carrying words W0..W7 in order, one word per cycle.
REQ-013 Words: W0=FFFFFFFF, W1=5599AA66, W2=04000000, W3=0C400080, W4=bitswap(addr), W5=0C000180, W6=000000F0, W7=04000000.
REQ-014 addr=image_sel_latched*IMAGE_STRIDE, truncated to 32 bits; image_sel_latched>=NUM_IMAGES SHALL be treated as 0.
REQ-015 bitswap SHALL reverse bit order within each byte independently, with byte positions unchanged.
REQ-016 After W7, on the next cycle: icap_csib=1, icap_rdwrb=1, icap_din=0, and the FSM -> DONE.
REQ-017 DONE SHALL be terminal until Reset; boot_req is ignored in DONE.
REQ-018 In SEND, boot_req and image_sel changes SHALL be ignored.
REQ-019 busy=1 in HOLD and SEND, else 0; done=1 only in DONE.
REQ-020 All outputs SHALL be registered, with no combinational path from boot_req to any output.
REQ-021 The first SEND cycle (W0 on icap_din, icap_csib=0) SHALL be the cycle after the qualifying edge.

Reset
REQ-022 On Reset: state=IDLE, icap_csib=1, icap_rdwrb=1, icap_din=0, busy=0, done=0, hold counter=0, latched select=0.
REQ-023 Reset asserted mid-SEND SHALL abort the sequence: icap_csib=1 from the next cycle, and no further words are sent.
REQ-024 Reset SHALL take priority over boot_req on the same edge.

Configuration
REQ-025 Macro ICAPE2_PRIM_EN defined: SHALL instantiate the ICAPE2 primitive (ICAP_WIDTH "X32") clocked by Clk, driven from icap_csib, icap_rdwrb and icap_din, with its O port unconnected; the output ports stay driven identically.
REQ-026 Macro ICAPE2_PRIM_EN undefined: SHALL NOT instantiate the primitive; only the ports are driven, for simulation or an external ICAP.

Structure
REQ-027 Package icap_pkg SHALL hold the command word constants (SYNC, NOOP, WR_WBSTAR, WR_CMD, IPROG, DUMMY), the state enum, and the bitswap function.
REQ-028 The hold counter SHALL be a sub-module, press_qualifier (boot_req in, qualified pulse out), parameterised by HOLD_CYCLES.

Verification
REQ-029 Bench: HOLD_CYCLES=1, image_sel=0, single-cycle boot_req -> W0..W7 on the next 8 cycles with W4=00000000, then icap_csib=1 and done=1.
REQ-030 Bench: NUM_IMAGES=4, IMAGE_STRIDE=00400000, image_sel=1 -> addr 00400000, W4=00020000.
REQ-031 Bench: HOLD_CYCLES=5, boot_req high 4 cycles then low -> icap_csib stays 1 and busy returns to 0; a 5-cycle press -> sequence starts on cycle 6.
REQ-032 Bench: Reset pulsed during W3 -> icap_csib=1 next cycle, state IDLE, done=0; a new request then yields a full 8-word sequence.
REQ-033 Bench: NUM_IMAGES=3, image_sel=3 -> W4=00000000; image_sel toggled during SEND -> W4 unaffected.
REQ-034 Bench: boot_req held high in DONE for 100 cycles -> no icap_csib=0 cycles.
